// File: rtl/msg_stream_engine.sv
// msg_stream_engine: writable message buffer streamed over valid/ready.
// Loop, one-shot and single-step modes; resets to the "siliconpr0n.org" banner.
module msg_stream_engine #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic               stop_on_nul,
  input  logic [ADDR_W:0]    msg_len,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rd_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [1:0] M_LOOP = 2'b00;
  localparam logic [1:0] M_ONE  = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;
  localparam logic [1:0] M_HOLD = 2'b11;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  function automatic logic [DATA_W-1:0] banner(input int i);
    logic [7:0] c;
    case (i)
      0:       c = "s";
      1:       c = "i";
      2:       c = "l";
      3:       c = "i";
      4:       c = "c";
      5:       c = "o";
      6:       c = "n";
      7:       c = "p";
      8:       c = "r";
      9:       c = "0";
      10:      c = "n";
      11:      c = ".";
      12:      c = "o";
      13:      c = "r";
      14:      c = "g";
      default: c = 8'h00;
    endcase
    return DATA_W'(c);
  endfunction

  state_e              state_q;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   buf_q [DEPTH];
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                done_q;
  logic [ADDR_W-1:0]   rd_idx_q;
  logic [PRESC_W-1:0]  presc_q;

  logic [DATA_W-1:0]   fetch_word;
  logic [ADDR_W:0]     eff_len;
  logic [ADDR_W:0]     last_idx;
  logic                wrap;
  logic                nul_hit;
  logic                pre_nz;
  logic [1:0]          end_mode;
  state_e              end_st;
  state_e              step_st;
  state_e              hs_st;

  assign fetch_word = buf_q[rd_idx_q];

  always_comb begin
    eff_len = msg_len;
    if (msg_len == '0 || msg_len > DEPTH_L)
      eff_len = DEPTH_L;
    last_idx = eff_len - (ADDR_W+1)'(1);
    wrap     = ({1'b0, rd_idx_q} == last_idx);
    nul_hit  = stop_on_nul && (fetch_word == '0);
    pre_nz   = (prescale != '0);
    // a handshake samples the live mode; a NUL end uses the latched one
    end_mode = (state_q == S_PRESENT) ? mode : mode_q;
    end_st   = S_IDLE;
    unique case (1'b1)
      end_mode == M_LOOP: end_st = pre_nz ? S_WAIT : S_FETCH;
      end_mode == M_ONE:  end_st = S_DONE;
      default:            end_st = S_IDLE;
    endcase
    step_st = S_IDLE;
    unique case (1'b1)
      mode == M_STEP,
      mode == M_HOLD: step_st = S_IDLE;
      default:        step_st = pre_nz ? S_WAIT : S_FETCH;
    endcase
    hs_st = wrap ? end_st : step_st;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= M_HOLD;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      rd_idx_q    <= '0;
      presc_q     <= '0;
      for (int i = 0; i < DEPTH; i++)
        buf_q[i] <= banner(i);
    end else if (ena) begin
      if (wr_en)
        buf_q[wr_addr] <= wr_data;
      unique case (state_q)
        S_IDLE: begin
          mode_q <= mode;
          if (mode == M_LOOP) begin
            state_q <= S_FETCH;
          end else if ((mode == M_ONE || mode == M_STEP) && start) begin
            state_q <= S_FETCH;
            done_q  <= 1'b0;
          end
        end
        S_FETCH: begin
          if (nul_hit) begin
            rd_idx_q <= '0;
            state_q  <= end_st;
            if (end_st == S_WAIT)
              presc_q <= prescale;
            if (end_st == S_DONE)
              done_q <= 1'b1;
          end else begin
            out_data_q  <= fetch_word;
            out_valid_q <= 1'b1;
            state_q     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            mode_q      <= mode;
            rd_idx_q    <= wrap ? '0 : rd_idx_q + ADDR_W'(1);
            state_q     <= hs_st;
            if (hs_st == S_WAIT)
              presc_q <= prescale;
            if (hs_st == S_DONE)
              done_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (presc_q <= PRESC_W'(1)) begin
            presc_q <= '0;
            state_q <= S_FETCH;
          end else begin
            presc_q <= presc_q - PRESC_W'(1);
          end
        end
        S_DONE: begin
          if (start) begin
            done_q   <= 1'b0;
            rd_idx_q <= '0;
            mode_q   <= mode;
            state_q  <= S_FETCH;
          end else if (mode == M_LOOP) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign rd_idx    = rd_idx_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_msg_stream_engine.sv
// tb_msg_stream_engine: directed vector bench for msg_stream_engine.
// Table-driven LOOP stream plus hand-written multi-cycle sequences.
module tb_msg_stream_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [1:0] mode;
  logic       start;
  logic       stop_on_nul;
  logic [4:0] msg_len;
  logic [7:0] prescale;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [3:0] rd_idx;

  always #5 clk = ~clk;

  msg_stream_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .mode       (mode),
    .start      (start),
    .stop_on_nul(stop_on_nul),
    .msg_len    (msg_len),
    .prescale   (prescale),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .rd_idx     (rd_idx)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [3:0] idx;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] ban [16];
  vec_t       tab [34];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string nm, input int max);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      ok = out_valid;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    ena         = 1'b1;
    mode        = 2'b11;
    start       = 1'b0;
    stop_on_nul = 1'b0;
    msg_len     = '0;
    prescale    = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    out_ready   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    string      s;
    logic [7:0] q [$];
    int         vc [$];
    logic       ok;
    int         n;
    logic [7:0] last;

    rst_n = 1'b0; ena = 1'b1; mode = 2'b11; start = 1'b0;
    stop_on_nul = 1'b0; msg_len = '0; prescale = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b1;

    s = "siliconpr0n.org";
    for (int i = 0; i < 15; i++) ban[i] = s[i];
    ban[15] = 8'h00;
    for (int k = 0; k < 34; k++) begin
      tab[k].v   = k[0];
      tab[k].idx = 4'((k / 2) % 16);
      tab[k].d   = ban[(k / 2) % 16];
    end

    // LOOP stream from reset
    do_reset();
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(rd_idx), 32'd0);
    mode = 2'b00;
    for (int k = 0; k < 34; k++) begin
      tick();
      chk("loop_valid", 32'(out_valid), 32'(tab[k].v));
      chk("loop_idx", 32'(rd_idx), 32'(tab[k].idx));
      chk("loop_busy", 32'(busy), 32'd1);
      if (tab[k].v) chk("loop_data", 32'(out_data), 32'(tab[k].d));
    end
    mode = 2'b11;
    tick();
    chk("hold_busy", 32'(busy), 32'd0);
    chk("hold_valid", 32'(out_valid), 32'd0);
    chk("hold_idx", 32'(rd_idx), 32'd1);
    repeat (2) tick();
    chk("hold_stay", 32'(busy), 32'd0);

    // ONESHOT with NUL stop, then replay
    do_reset();
    mode = 2'b01; stop_on_nul = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("os_busy", 32'(busy), 32'd1);
    q.delete();
    for (int i = 0; i < 80 && !done; i++) begin
      tick();
      if (out_valid) q.push_back(out_data);
    end
    chk("os_count", 32'(q.size()), 32'd15);
    for (int i = 0; i < q.size() && i < 15; i++)
      chk("os_word", 32'(q[i]), 32'(ban[i]));
    chk("os_done", 32'(done), 32'd1);
    chk("os_idle", 32'(busy), 32'd0);
    chk("os_novalid", 32'(out_valid), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("os_clr", 32'(done), 32'd0);
    chk("os_ridx", 32'(rd_idx), 32'd0);
    tick();
    chk("os_rvalid", 32'(out_valid), 32'd1);
    chk("os_rdata", 32'(out_data), 32'(ban[0]));

    // ONESHOT stall on third word with a write to its address
    do_reset();
    mode = 2'b01; stop_on_nul = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = out_valid && (out_data == ban[1]);
    end
    chk("st_reach", 32'(ok), 32'd1);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("st_valid", 32'(out_valid), 32'd1);
      chk("st_data", 32'(out_data), 32'(ban[2]));
      if (i == 2) begin
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h41;
      end else begin
        wr_en = 1'b0;
      end
    end
    out_ready = 1'b1;
    tick();
    chk("st_release", 32'(out_valid), 32'd0);
    tick();
    chk("st_next", 32'(out_data), 32'(ban[3]));
    for (int i = 0; i < 60 && !done; i++) tick();
    chk("st_done", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; last = '0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      tick();
      if (out_valid) begin
        n++;
        last = out_data;
      end
    end
    chk("st_written", 32'(last), 32'h41);

    // LOOP, short length with prescaler
    do_reset();
    msg_len = 5'd3; prescale = 8'd4; mode = 2'b00;
    q.delete(); vc.delete();
    for (int c = 0; c < 80 && q.size() < 6; c++) begin
      tick();
      if (out_valid) begin
        q.push_back(out_data);
        vc.push_back(c);
      end
    end
    chk("ps_count", 32'(q.size()), 32'd6);
    for (int i = 0; i < q.size(); i++) begin
      chk("ps_word", 32'(q[i]), 32'(ban[i % 3]));
      if (i > 0) chk("ps_gap", 32'(vc[i] - vc[i-1]), 32'd6);
    end

    // STEP with ignored extra starts
    do_reset();
    mode = 2'b10; out_ready = 1'b0;
    for (int st = 0; st < 3; st++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("sp_busy", 32'(busy), 32'd1);
      tick();
      chk("sp_valid", 32'(out_valid), 32'd1);
      chk("sp_data", 32'(out_data), 32'(ban[st]));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("sp_hold", 32'(out_valid), 32'd1);
      chk("sp_hdata", 32'(out_data), 32'(ban[st]));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("sp_idle", 32'(busy), 32'd0);
      chk("sp_novalid", 32'(out_valid), 32'd0);
      chk("sp_idx", 32'(rd_idx), 32'(st + 1));
      tick();
      chk("sp_stay", 32'(busy), 32'd0);
    end

    // ena freeze, then reset mid-sequence
    do_reset();
    mode = 2'b00;
    wait_valid("en_first", 10);
    chk("en_data", 32'(out_data), 32'(ban[0]));
    ena = 1'b0; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h5A;
    repeat (5) begin
      tick();
      chk("en_frz_valid", 32'(out_valid), 32'd1);
      chk("en_frz_data", 32'(out_data), 32'(ban[0]));
      chk("en_frz_idx", 32'(rd_idx), 32'd0);
    end
    ena = 1'b1; wr_en = 1'b0;
    tick();
    chk("en_resume", 32'(out_valid), 32'd0);
    tick();
    chk("en_bvalid", 32'(out_valid), 32'd1);
    chk("en_blocked", 32'(out_data), 32'(ban[1]));
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h58;
    tick();
    wr_en = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_data", 32'(out_data), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_idx", 32'(rd_idx), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_valid("mr_first", 10);
    chk("mr_banner", 32'(out_data), 32'(ban[0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msg_stream_engine.md
Name: msg_stream_engine

Overview:
- Parametrised successor to the fixed free-running ASCII string counter.
- Holds a writable message buffer that resets to the default banner "siliconpr0n.org" followed by NUL.
- Streams buffer words over a valid/ready interface, with loop, one-shot and single-step modes, a programmable length, an optional NUL terminator and a rate prescaler.
- Sits between the top-level pin mux and uo_out; the top level drives the mode and control pins from ui_in/uio_in.

Parameters:
- DATA_W, 8, width of a message word.
- DEPTH, 16, number of buffer entries; a power of two, at least 16.
- ADDR_W, 4, log2(DEPTH).
- PRESC_W, 8, width of the prescaler reload value.

Ports:
- clk  in  1  single design clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state.
- mode  in  2  operating mode: 00 LOOP, 01 ONESHOT, 10 STEP, 11 HOLD.
- start  in  1  single-cycle pulse; starts a one-shot sequence or advances one step.
- stop_on_nul  in  1  when 1, a zero word ends the sequence.
- msg_len  in  ADDR_W+1  number of words in the sequence, 1..DEPTH; a value of 0 or greater than DEPTH means DEPTH.
- prescale  in  PRESC_W  idle cycles inserted after each accepted word.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  ADDR_W  buffer write address.
- wr_data  in  DATA_W  buffer write data.
- out_data  out  DATA_W  current word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the word.
- busy  out  1  a sequence is in progress (state is not IDLE or DONE).
- done  out  1  a one-shot sequence has completed; sticky.
- rd_idx  out  ADDR_W  buffer index of the current or next word.

Behaviour:
- Asynchronous reset values:
  - out_data=0, out_valid=0, busy=0, done=0, rd_idx=0, prescaler=0, state IDLE.
  - Buffer entries 0..14 reset to "siliconpr0n.org"; entry 15 and all entries above it reset to 0.
- Buffer writes:
  - Take effect on the clock edge when wr_en=1 and ena=1, in any state.
- States and transitions:
  - IDLE: LOOP enters FETCH immediately. ONESHOT and STEP enter FETCH when start=1. HOLD stays in IDLE.
  - FETCH (1 cycle): read buf[rd_idx].
    - If stop_on_nul=1 and the word is 0, take END_SEQ.
    - Otherwise register the word into out_data, set out_valid=1 and enter PRESENT.
  - PRESENT: out_data and out_valid stay stable until out_ready=1; a write to buf[rd_idx] does not alter the held out_data.
    - Handshake cycle: out_valid=1 and out_ready=1. On that edge, clear out_valid and advance rd_idx.
    - rd_idx wraps to 0 when it reaches msg_len-1 or the buffer end; a wrap counts as END_SEQ.
    - Non-wrapping handshake: go to WAIT if prescale is nonzero, otherwise straight to FETCH.
    - In STEP mode, a non-wrapping handshake returns to IDLE instead.
  - WAIT: count down from prescale, then enter FETCH. STEP mode never enters WAIT.
  - END_SEQ: LOOP sets rd_idx=0 and continues (via WAIT or FETCH). ONESHOT sets done=1 and enters DONE. STEP sets rd_idx=0 and returns to IDLE.
  - DONE: start=1 clears done, sets rd_idx=0 and enters FETCH. Selecting LOOP mode returns to IDLE.
- Latency and throughput:
  - start to out_valid is 2 cycles.
  - With prescale=0 and out_ready held high, one word is delivered every 2 cycles (FETCH followed by the handshake).
- Mode changes:
  - A change is sampled only in IDLE, DONE, or on a handshake.
  - A change to HOLD while active completes the current PRESENT, then goes to IDLE with rd_idx kept.
- Simultaneous and boundary events:
  - start is ignored outside IDLE and DONE.
  - A write colliding with a FETCH of the same address returns the old value.
  - ena=0 freezes all state and outputs, including out_valid; buffer writes are blocked.
  - In LOOP with stop_on_nul=1 and buf[0]=0, the block cycles through FETCH and END_SEQ with out_valid never asserting; this is legal.
  - Reset mid-sequence restores the default buffer and the IDLE state.
- Arithmetic:
  - rd_idx increments modulo the effective length.
  - The prescaler is an unsigned down-counter; prescale is sampled on WAIT entry.

Test Plan:
- After reset, LOOP mode, out_ready=1, prescale=0 -> out_data sequence 's','i','l',…,'g' (15 words); the NUL is presented because stop_on_nul=0, then wraps to 's'; out_valid toggles every 2 cycles.
- ONESHOT, stop_on_nul=1, start pulse -> exactly 15 words "siliconpr0n.org", then done=1 and busy=0; a second start replays from 's' and clears done on the start cycle.
- ONESHOT, out_ready held low for 10 cycles on the 3rd word -> out_data stays 'l' and out_valid stays high throughout; wr_en to index 2 with 0x41 during the stall leaves out_data='l'.
- LOOP, msg_len=3, prescale=4 -> repeating 's','i','l' with 5 cycles from handshake to the next out_valid.
- STEP, three start pulses -> one word each ('s','i','l'), IDLE between pulses; extra start pulses during PRESENT are ignored.
- LOOP, ena deasserted for 5 cycles mid-PRESENT, then rst_n pulsed mid-sequence -> state frozen while ena is low; after reset all outputs are 0 and the buffer holds the default banner.
